// File: rtl/operand_fetch_ctrl.sv
// Operand-fetch sequencer in front of the single-port 32x32 register bank: queues writebacks,
// arbitrates the bank port, captures read operands. Optional OPERAND_BYPASS_EN forwards queued writes.
module operand_fetch_ctrl #(
  parameter int WB_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rstBar,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [4:0]                req_rs1,
  input  logic [4:0]                req_rs2,
  output logic                      op_valid,
  input  logic                      op_ready,
  output logic [31:0]               op_rs1_data,
  output logic [31:0]               op_rs2_data,
  input  logic                      wb_valid,
  output logic                      wb_ready,
  input  logic [4:0]                wb_rd,
  input  logic [31:0]               wb_data,
  output logic [$clog2(WB_DEPTH):0] wb_pending,
  output logic                      rb_csbar,
  output logic                      rb_rdwrbar,
  output logic [4:0]                rb_sel_src0,
  output logic [4:0]                rb_sel_src1,
  output logic [4:0]                rb_sel_dst,
  output logic [31:0]               rb_dst,
  input  logic [31:0]               rb_src0,
  input  logic [31:0]               rb_src1
);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(WB_DEPTH);

  // Handshakes: a transfer happens on the posedge where valid & ready are both high.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [4:0]    rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0]   op1_q, op1_d, op2_q, op2_d;
  logic [4:0]    fifo_rd_q   [WB_DEPTH];
  logic [31:0]   fifo_data_q [WB_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, idx;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, req_fire, hit1, hit2;
  logic [31:0]   rd0_val, rd1_val;
`ifdef OPERAND_BYPASS_EN
  logic          byp1_q, byp1_d, byp2_q, byp2_d;
  logic [31:0]   snap1_q, snap1_d, snap2_q, snap2_d, match1, match2;
`endif

  // Scan every live entry oldest-to-youngest so the last hit is the youngest match.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    idx  = '0;
`ifdef OPERAND_BYPASS_EN
    match1 = '0;
    match2 = '0;
`endif
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (req_rs1 != 5'd0 && fifo_rd_q[idx] == req_rs1) begin
          hit1 = 1'b1;
`ifdef OPERAND_BYPASS_EN
          match1 = fifo_data_q[idx];
`endif
        end
        if (req_rs2 != 5'd0 && fifo_rd_q[idx] == req_rs2) begin
          hit2 = 1'b1;
`ifdef OPERAND_BYPASS_EN
          match2 = fifo_data_q[idx];
`endif
        end
      end
    end
  end

`ifdef OPERAND_BYPASS_EN
  assign req_ready = (state_q == S_IDLE) && (count_q != FULL);
  assign rd0_val   = byp1_q ? snap1_q : rb_src0;
  assign rd1_val   = byp2_q ? snap2_q : rb_src1;
`else
  assign req_ready = (state_q == S_IDLE) && (count_q != FULL) && !(hit1 || hit2);
  assign rd0_val   = rb_src0;
  assign rd1_val   = rb_src1;
`endif

  assign req_fire    = req_valid && req_ready;
  assign wb_ready    = (count_q != FULL);
  assign push        = wb_valid && wb_ready && (wb_rd != 5'd0);
  assign pop         = (state_q != S_ISSUE) && (count_q != '0);
  assign wb_pending  = count_q;
  assign op_valid    = (state_q == S_HOLD);
  assign op_rs1_data = op1_q;
  assign op_rs2_data = op2_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
`ifdef OPERAND_BYPASS_EN
    byp1_d  = byp1_q;
    byp2_d  = byp2_q;
    snap1_d = snap1_q;
    snap2_d = snap2_q;
`endif
    case (state_q)
      S_IDLE: if (req_fire) begin
        rs1_d   = req_rs1;
        rs2_d   = req_rs2;
        state_d = S_ISSUE;
`ifdef OPERAND_BYPASS_EN
        byp1_d  = hit1;
        byp2_d  = hit2;
        snap1_d = match1;
        snap2_d = match2;
`endif
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        op1_d   = (rs1_q == 5'd0) ? 32'd0 : rd0_val;
        op2_d   = (rs2_q == 5'd0) ? 32'd0 : rd1_val;
        state_d = S_HOLD;
      end
      S_HOLD: if (op_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The read owns the port only in ISSUE; every other cycle drains the FIFO head if present.
  always_comb begin
    rb_csbar    = 1'b1;
    rb_rdwrbar  = 1'b1;
    rb_sel_src0 = 5'd0;
    rb_sel_src1 = 5'd0;
    rb_sel_dst  = 5'd0;
    rb_dst      = 32'd0;
    if (state_q == S_ISSUE) begin
      rb_csbar    = 1'b0;
      rb_sel_src0 = rs1_q;
      rb_sel_src1 = rs2_q;
    end else if (count_q != '0) begin
      rb_csbar   = 1'b0;
      rb_rdwrbar = 1'b0;
      rb_sel_dst = fifo_rd_q[rd_ptr_q];
      rb_dst     = fifo_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstBar) begin
      state_q  <= S_IDLE;
      rs1_q    <= 5'd0;
      rs2_q    <= 5'd0;
      op1_q    <= 32'd0;
      op2_q    <= 32'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef OPERAND_BYPASS_EN
      byp1_q   <= 1'b0;
      byp2_q   <= 1'b0;
      snap1_q  <= 32'd0;
      snap2_q  <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef OPERAND_BYPASS_EN
      byp1_q   <= byp1_d;
      byp2_q   <= byp2_d;
      snap1_q  <= snap1_d;
      snap2_q  <= snap2_d;
`endif
    end
  end

  // Entry storage needs no reset: liveness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= wb_rd;
      fifo_data_q[wr_ptr_q] <= wb_data;
    end
  end
endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Bench for operand_fetch_ctrl: register-bank model, directed and random traffic, and an
// architectural-state reference model feeding a scoreboard of expected operands.
module tb_operand_fetch_ctrl;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rstBar, req_valid, req_ready, op_valid, op_ready, wb_valid, wb_ready;
  logic [4:0]  req_rs1, req_rs2, wb_rd, rb_sel_src0, rb_sel_src1, rb_sel_dst;
  logic [31:0] op_rs1_data, op_rs2_data, wb_data, rb_dst, rb_src0, rb_src1;
  logic [2:0]  wb_pending;
  logic        rb_csbar, rb_rdwrbar;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  logic [31:0] bank_mem [32];
  logic [31:0] bank_src0, bank_src1;
  bit          bank_init;

  // Reference model: architectural register values as of each accepted write, the queue of
  // writes not yet in the bank, and the expected operand pairs.
  logic [31:0] arch [32];
  logic [36:0] pq[$];
  logic [63:0] exp_q[$];
  bit          busy, issue_now, wr_now, exp_ov, haz;
  int          acc_cycle;
  logic [4:0]  cur_rs1, cur_rs2;

  operand_fetch_ctrl #(.WB_DEPTH(D)) dut (
    .clk(clk), .rstBar(rstBar),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .op_valid(op_valid), .op_ready(op_ready), .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_pending(wb_pending),
    .rb_csbar(rb_csbar), .rb_rdwrbar(rb_rdwrbar), .rb_sel_src0(rb_sel_src0),
    .rb_sel_src1(rb_sel_src1), .rb_sel_dst(rb_sel_dst), .rb_dst(rb_dst),
    .rb_src0(rb_src0), .rb_src1(rb_src1)
  );

  assign rb_src0 = bank_src0;
  assign rb_src1 = bank_src1;

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Register bank: registered read, source outputs junk (src1 zero when deselected) otherwise.
  always @(posedge clk) begin
    if (!bank_init) begin
      for (int r = 0; r < 32; r++) bank_mem[r] <= $urandom;
      bank_init <= 1'b1;
    end else if (rb_csbar === 1'b0 && rb_rdwrbar === 1'b0) begin
      bank_mem[rb_sel_dst] <= rb_dst;
    end
    if (rb_csbar === 1'b0 && rb_rdwrbar === 1'b1) begin
      bank_src0 <= bank_mem[rb_sel_src0];
      bank_src1 <= bank_mem[rb_sel_src1];
    end else begin
      bank_src0 <= $urandom;
      bank_src1 <= (rb_csbar === 1'b0) ? $urandom : 32'h0;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rstBar) begin
      pq.delete();
      exp_q.delete();
      busy = 1'b0;
      for (int r = 0; r < 32; r++) arch[r] = bank_mem[r];
    end else begin
      issue_now = busy && (cycle == acc_cycle + 1);
      wr_now    = !issue_now && (pq.size() != 0);
      exp_ov    = busy && (cycle >= acc_cycle + 3);
      haz       = 1'b0;
      foreach (pq[i])
        if ((req_rs1 != 5'd0 && pq[i][36:32] == req_rs1) ||
            (req_rs2 != 5'd0 && pq[i][36:32] == req_rs2)) haz = 1'b1;
`ifdef OPERAND_BYPASS_EN
      haz = 1'b0;
`endif
      chk("wb_pending", wb_pending, pq.size());
      chk("wb_ready", wb_ready, pq.size() != D);
      chk("req_ready", req_ready, !busy && !haz && (pq.size() != D));
      chk("op_valid", op_valid, exp_ov);
      if (exp_ov && exp_q.size() > 0) begin
        chk("op_rs1_data", op_rs1_data, exp_q[0][63:32]);
        chk("op_rs2_data", op_rs2_data, exp_q[0][31:0]);
      end
      if (issue_now) begin
        chk("rd_csbar", rb_csbar, 0);
        chk("rd_rdwrbar", rb_rdwrbar, 1);
        chk("rd_sel_src0", rb_sel_src0, cur_rs1);
        chk("rd_sel_src1", rb_sel_src1, cur_rs2);
      end else if (wr_now) begin
        chk("wr_csbar", rb_csbar, 0);
        chk("wr_rdwrbar", rb_rdwrbar, 0);
        chk("wr_sel_dst", rb_sel_dst, pq[0][36:32]);
        chk("wr_dst", rb_dst, pq[0][31:0]);
      end else begin
        chk("idle_csbar", rb_csbar, 1);
        chk("idle_rdwrbar", rb_rdwrbar, 1);
        chk("idle_sels", {rb_sel_src0, rb_sel_src1, rb_sel_dst}, 0);
        chk("idle_dst", rb_dst, 0);
      end
      if (wr_now) void'(pq.pop_front());
      if (exp_ov && op_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        busy = 1'b0;
      end
      if (req_valid && req_ready) begin
        exp_q.push_back({(req_rs1 == 5'd0) ? 32'd0 : arch[req_rs1],
                         (req_rs2 == 5'd0) ? 32'd0 : arch[req_rs2]});
        busy = 1'b1;
        acc_cycle = cycle;
        cur_rs1 = req_rs1;
        cur_rs2 = req_rs2;
      end
      if (wb_valid && wb_ready && wb_rd != 5'd0) begin
        arch[wb_rd] = wb_data;
        pq.push_back({wb_rd, wb_data});
      end
    end
  end

  // Driver tasks
  task automatic push_wb(input logic [4:0] rd, input logic [31:0] d);
    int n = 0;
    wb_valid = 1'b1; wb_rd = rd; wb_data = d;
    @(negedge clk);
    while (!wb_ready && n < 200) begin @(negedge clk); n++; end
    chk("wb_accept_timeout", wb_ready, 1);
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  task automatic req(input logic [4:0] r1, input logic [4:0] r2);
    int n = 0;
    req_valid = 1'b1; req_rs1 = r1; req_rs2 = r2;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    chk("req_accept_timeout", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic consume(input int hold);
    int n = 0;
    op_ready = 1'b0;
    @(negedge clk);
    while (!op_valid && n < 200) begin @(negedge clk); n++; end
    chk("op_valid_timeout", op_valid, 1);
    repeat (hold) @(negedge clk);
    @(posedge clk); #1;
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
  endtask

  task automatic do_reset();
    rstBar = 1'b0; req_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstBar = 1'b1;
    @(negedge clk);
    chk("reset_op_rs1_data", op_rs1_data, 0);
    chk("reset_op_rs2_data", op_rs2_data, 0);
    @(posedge clk); #1;
  endtask

  initial begin : main
    bit w_acc, r_acc;
    req_rs1 = 0; req_rs2 = 0; wb_rd = 0; wb_data = 0;
    do_reset();

    // Write then read, with operands held under backpressure
    push_wb(5'd5, 32'hDEADBEEF);
    repeat (2) @(posedge clk); #1;
    req(5'd5, 5'd0);
    consume(5);

    // Writes to x0 are dropped; x0 reads as zero
    push_wb(5'd0, 32'h1234);
    repeat (2) @(posedge clk); #1;
    req(5'd0, 5'd0);
    consume(0);

    // Writes drain while operands sit in HOLD
    req(5'd1, 5'd2);
    for (int i = 1; i <= 4; i++) push_wb(5'(i), $urandom);
    consume(1);

    // Streaming writes plus repeated reads fill the FIFO (each ISSUE steals a drain slot)
    fork
      begin for (int i = 0; i < 24; i++) push_wb(5'(10 + i % 8), $urandom); end
      begin for (int j = 0; j < 6; j++) begin req(5'd20, 5'd21); consume(0); end end
    join

    // Hazard on a queued write to the requested register
    push_wb(5'd7, 32'hA5A5A5A5);
    req(5'd7, 5'd3);
    consume(0);

    // Two queued writes to one register; the read must see the younger
    push_wb(5'd9, 32'd1);
    push_wb(5'd9, 32'd2);
    req(5'd0, 5'd9);
    consume(0);

    // Random traffic with a reset in the middle
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      w_acc = wb_valid && wb_ready;
      r_acc = req_valid && req_ready;
      @(posedge clk); #1;
      if (n == 700) begin
        do_reset();
        continue;
      end
      if (!wb_valid || w_acc) begin
        wb_valid = ($urandom_range(0, 99) < 45);
        wb_rd    = 5'($urandom_range(0, 7));
        wb_data  = $urandom;
      end
      if (!req_valid || r_acc) begin
        req_valid = ($urandom_range(0, 99) < 50);
        req_rs1   = 5'($urandom_range(0, 7));
        req_rs2   = 5'($urandom_range(0, 7));
      end
      op_ready = 1'($urandom_range(0, 1));
    end

    // Let everything drain, then the bank must hold the architectural state
    wb_valid = 1'b0; req_valid = 1'b0; op_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("final_pending", wb_pending, 0);
    for (int r = 1; r < 32; r++) chk("final_bank", bank_mem[r], arch[r]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/operand_fetch_ctrl.md
Name: operand_fetch_ctrl

Overview:
- Sequencer sitting directly upstream of the 32x32 register bank (single access port; read and write are mutually exclusive per clock).
- Accepts operand-read requests from decode and result writebacks from execute.
- Queues writebacks in a small FIFO, arbitrates the bank's CSBar/RDWRBar port, and captures the read data into holding registers.
- Presents the captured operands downstream with a valid/ready handshake.

Parameters:
- WB_DEPTH, 4, writeback FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  clock; all logic on posedge.
- rstBar  in  1  synchronous active-low reset.
- req_valid  in  1  operand-read request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_rs1  in  5  source register 1 index.
- req_rs2  in  5  source register 2 index.
- op_valid  out  1  operands valid.
- op_ready  in  1  downstream consumes operands.
- op_rs1_data  out  32  operand 1.
- op_rs2_data  out  32  operand 2.
- wb_valid  in  1  writeback valid.
- wb_ready  out  1  writeback accepted when wb_valid & wb_ready.
- wb_rd  in  5  destination index.
- wb_data  in  32  writeback data.
- wb_pending  out  $clog2(WB_DEPTH)+1  FIFO occupancy.
- rb_csbar  out  1  to bank CSBar (0 = access).
- rb_rdwrbar  out  1  to bank RDWRBar (1 = read, 0 = write).
- rb_sel_src0  out  5  to bank regSelSrc0.
- rb_sel_src1  out  5  to bank regSelSrc1.
- rb_sel_dst  out  5  to bank regSelDst.
- rb_dst  out  32  to bank regDst.
- rb_src0  in  32  from bank regSrc0.
- rb_src1  in  32  from bank regSrc1.

Behaviour:
- Reset (rstBar=0 at posedge):
  - state=IDLE, FIFO empty, wb_pending=0, op_valid=0, op_rs1_data=op_rs2_data=0.
  - rb_csbar=1, rb_rdwrbar=1.
  - Reset mid-operation abandons any read in flight and flushes queued writes.
- rb_* are combinational from state/FIFO head. When the port is unused: rb_csbar=1, rb_rdwrbar=1, selects 0, rb_dst 0.
- The bank zeroes regSrc1 while deselected, so rb_src* are sampled only in WAIT.
- States:
  - IDLE: req_ready = !hazard & (wb_pending != WB_DEPTH). On accept, latch rs1/rs2 and go to ISSUE.
  - ISSUE (1 cycle): rb_csbar=0, rb_rdwrbar=1, rb_sel_src0=rs1, rb_sel_src1=rs2. Go to WAIT.
  - WAIT (1 cycle): capture op_rs1_data = (rs1==0) ? 0 : rb_src0, and op_rs2_data likewise from rb_src1. Go to HOLD.
  - HOLD: op_valid=1; data stable until op_ready. On op_ready, go to IDLE. req_ready=0 in HOLD, so back-to-back issue is one request per 4 cycles minimum.
- Latency: accept in cycle c → ISSUE c+1 → WAIT c+2 → op_valid in c+3.
- Write drain:
  - In any cycle where state != ISSUE and the FIFO is non-empty, drive rb_csbar=0, rb_rdwrbar=0, rb_sel_dst=head.rd, rb_dst=head.data.
  - Pop the head at that edge.
  - Writes are in order, one per cycle.
- Write enqueue:
  - wb_ready = (wb_pending != WB_DEPTH).
  - Accepted writes with wb_rd==0 are discarded, not enqueued.
  - Push and pop in the same cycle leaves occupancy unchanged; pointers wrap modulo WB_DEPTH.
- Hazard:
  - Asserted when any valid FIFO entry (including the head being popped this cycle) has rd == req_rs1 or rd == req_rs2, with that rs != 0.
  - Stall until the matching entries drain.
- A write arriving after a read is accepted is never forwarded into that read.
- Read sees writes drained on or before the ISSUE edge.

Optional Feature:
- Macro: OPERAND_BYPASS_EN.
- Defined:
  - Hazard no longer blocks req_ready.
  - At acceptance, for each operand with a matching FIFO entry, snapshot the youngest matching entry's data and set a per-operand bypass flag.
  - In WAIT, a flagged operand takes its snapshot instead of rb_src*.
  - Latency is unchanged.
- Undefined: stall behaviour as above; no snapshot registers are instantiated.

Test Plan:
- Reset values: hold rstBar=0 for 2 clks → op_valid=0, rb_csbar=1, rb_rdwrbar=1, wb_pending=0, wb_ready=1, req_ready=1.
- Write then read:
  - wb rd=5 data=0xDEADBEEF → next cycle rb_csbar=0, rb_rdwrbar=0, rb_sel_dst=5.
  - Afterwards req rs1=5, rs2=0 → op_valid 3 cycles after accept, op_rs1_data=0xDEADBEEF, op_rs2_data=0.
  - Hold op_ready=0 for 5 cycles → data stable.
- x0 discard: wb rd=0 data=0x1234 → wb_pending stays 0, no write cycle; a later read of rs1=0 returns 0.
- Backpressure:
  - With op held in HOLD, push 4 writes to rd=1..4 → writes drain, one per cycle.
  - Stall drain by issuing a read, then fill the FIFO → wb_ready=0 at wb_pending=4.
  - Accept resumes after the next pop.
- Hazard (macro off):
  - Enqueue rd=7 data=0xA5A5A5A5, then present rs1=7 in the same cycle → req_ready=0 until the entry drains.
  - Result op_rs1_data=0xA5A5A5A5.
- Bypass (macro on):
  - Enqueue rd=9 data=1, then rd=9 data=2, then present rs2=9 → accepted immediately, op_rs2_data=2.
